// File: rtl/sine_dac_spi.sv
// sine_dac_spi
// Serialises 10-bit sine samples into 16-bit SPI frames (mode 0, MSB first)
// for a serial DAC. Frame layout: {CTRL_BITS, sample[9:0], 2'b00}.
// A one-entry holding buffer decouples the sample producer from the frame
// timing, so the next sample can be taken while the current frame shifts out.
//
// Build option: define SINE_DAC_TWOS_COMP_IN_EN to treat sample_in as two's
// complement. Bit 9 is then inverted on capture, which converts the sample to
// the offset-binary code the DAC expects. Without the macro the sample is
// passed through unchanged as unsigned data.
module sine_dac_spi #(
    parameter int unsigned CLK_DIV   = 2,        // clk cycles per SCLK half-period (1..255)
    parameter logic [3:0]  CTRL_BITS = 4'b0011   // DAC command nibble leading every frame
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_mosi,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Terminal count of the 8-bit divider; it wraps to 0 at each SCLK toggle
    // and at the end of HOLD.
    localparam logic [7:0] DIV_TC   = 8'(CLK_DIV - 1);
    // Index of the final falling edge (16 falls per frame, counted 0..15).
    localparam logic [3:0] LAST_BIT = 4'd15;

    state_t      state_q, state_d;

    logic [9:0]  buf_data_q, buf_data_d;
    logic        buf_valid_q, buf_valid_d;

    // Only the 15 bits still to be sent are kept; bit 15 goes straight to MOSI
    // when the frame loads.
    logic [14:0] shreg_q, shreg_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;

    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        frame_done_q, frame_done_d;

    logic [9:0]  sample_conv;
    logic [15:0] frame_word;
    logic        hs_fire;
    logic        load_fire;
    logic        div_tc;
    logic        sclk_fall;
    logic        last_fall;

`ifdef SINE_DAC_TWOS_COMP_IN_EN
    // Two's complement to offset binary: flip the sign bit.
    assign sample_conv = {~sample_in[9], sample_in[8:0]};
`else
    assign sample_conv = sample_in;
`endif

    assign frame_word = {CTRL_BITS, buf_data_q, 2'b00};
    assign hs_fire    = sample_valid & ~buf_valid_q;
    assign load_fire  = (state_q == ST_IDLE) & buf_valid_q;
    assign div_tc     = (div_cnt_q == DIV_TC);
    assign sclk_fall  = (state_q == ST_SHIFT) & div_tc & sclk_q;
    assign last_fall  = sclk_fall & (bit_cnt_q == LAST_BIT);

    // State register: the FSM always returns to IDLE on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SHIFT on a buffered sample, SHIFT -> HOLD on
    // the 16th falling SCLK edge, HOLD -> IDLE after CLK_DIV cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (buf_valid_q) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_fall) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (div_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: status flags decode directly from state and buffer; the
    // SPI pins come straight from registers so they never glitch.
    always_comb begin
        busy         = (state_q != ST_IDLE);
        sample_ready = ~buf_valid_q;
        dac_cs_n     = cs_n_q;
        dac_sclk     = sclk_q;
        dac_mosi     = mosi_q;
        frame_done   = frame_done_q;
    end

    // Holding buffer: a handshake always wins over the transfer into the
    // shifter. The two cannot coincide (ready is low whenever a transfer is
    // pending), but the ordering makes loss or duplication impossible anyway.
    always_comb begin
        buf_data_d  = buf_data_q;
        buf_valid_d = buf_valid_q;
        if (hs_fire) begin
            buf_data_d  = sample_conv;
            buf_valid_d = 1'b1;
        end else if (load_fire) begin
            buf_valid_d = 1'b0;
        end
    end

    // Frame engine: divider, SCLK generation, bit counting and MOSI shifting.
    // MOSI only moves on falling SCLK edges, so it is stable at every rise.
    always_comb begin
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        cs_n_d       = cs_n_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                cs_n_d    = 1'b1;
                sclk_d    = 1'b0;
                mosi_d    = 1'b0;
                if (load_fire) begin
                    // CS falls with bit 15 already on MOSI; SCLK stays low
                    // for one full half-period before the first rise.
                    shreg_d = frame_word[14:0];
                    mosi_d  = frame_word[15];
                    cs_n_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (div_tc) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (sclk_fall) begin
                        if (last_fall) begin
                            // Frame complete: release the bus into HOLD.
                            cs_n_d    = 1'b1;
                            sclk_d    = 1'b0;
                            mosi_d    = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            mosi_d    = shreg_q[14];
                            shreg_d   = {shreg_q[13:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                // CS stays high for CLK_DIV cycles; frame_done marks the exit.
                if (div_tc) begin
                    div_cnt_d    = '0;
                    frame_done_d = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                cs_n_d    = 1'b1;
                sclk_d    = 1'b0;
                mosi_d    = 1'b0;
            end
        endcase
    end

    // Datapath registers: reset aborts any frame in flight and parks the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data_q   <= '0;
            buf_valid_q  <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            buf_data_q   <= buf_data_d;
            buf_valid_q  <= buf_valid_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_sine_dac_spi.sv
// tb_sine_dac_spi
// Two instances (CLK_DIV=2 and CLK_DIV=1) share clock and reset. A bus
// monitor decodes every CS-low window into a frame record; the main thread
// offers samples, predicts each frame word arithmetically and compares.
// Works with or without SINE_DAC_TWOS_COMP_IN_EN defined.
module tb_sine_dac_spi;

    localparam logic [3:0] CTRL      = 4'b0011;
    localparam int         DIV0      = 2;
    localparam int         DIV1      = 1;
    localparam int         MON_DEPTH = 512;
    localparam int         TMO       = 4000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sin0  = '0;
    logic [9:0] sin1  = '0;
    logic [1:0] sval  = '0;
    logic [1:0] rdy, cs_n, sclk, mosi, busy, fd;

    always #5 clk = ~clk;

    sine_dac_spi #(.CLK_DIV(DIV0), .CTRL_BITS(CTRL)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sample_in(sin0), .sample_valid(sval[0]),
        .sample_ready(rdy[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]),
        .dac_mosi(mosi[0]), .busy(busy[0]), .frame_done(fd[0])
    );

    sine_dac_spi #(.CLK_DIV(DIV1), .CTRL_BITS(CTRL)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sample_in(sin1), .sample_valid(sval[1]),
        .sample_ready(rdy[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]),
        .dac_mosi(mosi[1]), .busy(busy[1]), .frame_done(fd[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: frame = CTRL*4096 + code*4, code offset by half-scale when the
    // input is two's complement.
    function automatic logic [15:0] model_frame(input logic [9:0] s);
        int code;
        code = int'(s);
`ifdef SINE_DAC_TWOS_COMP_IN_EN
        code = (code + 512) % 1024;
`endif
        return 16'(int'(CTRL) * 4096 + code * 4);
    endfunction

    function automatic logic [15:0] lit(input logic [15:0] plain, input logic [15:0] twos);
        logic [15:0] v;
        v = plain;
`ifdef SINE_DAC_TWOS_COMP_IN_EN
        v = twos;
`endif
        return v;
    endfunction

    // Scoreboard
    logic [15:0] exp0[$];
    logic [15:0] exp1[$];
    int exp_frames [2] = '{0, 0};
    int chk_idx    [2] = '{0, 0};

    // Monitor records
    logic [15:0] mon_word [2][MON_DEPTH];
    int          mon_rise [2][MON_DEPTH];
    int          mon_low  [2][MON_DEPTH];
    bit          mon_tim  [2][MON_DEPTH];
    int          mon_gap  [2][MON_DEPTH];
    int          mon_cnt  [2] = '{0, 0};
    int          fd_cnt   [2] = '{0, 0};
    int          viol     [2] = '{0, 0};

    logic [15:0] cur_word [2];
    int          cur_rise [2], cur_low [2], last_rise [2], gap [2], pend_gap [2];
    bit          cur_tim  [2];
    logic        p_cs [2], p_sclk [2], p_mosi [2], p_fd [2];

    // Bus monitor, sampled on the falling clk edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            cur_word[k] = '0; cur_rise[k] = 0; cur_low[k] = 0; last_rise[k] = 0;
            gap[k] = 0; pend_gap[k] = 0; cur_tim[k] = 1'b1;
            p_cs[k] = 1'b1; p_sclk[k] = 1'b0; p_mosi[k] = 1'b0; p_fd[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic c, s, m, f;
                int   dv;
                c  = cs_n[k]; s = sclk[k]; m = mosi[k]; f = fd[k];
                dv = (k == 0) ? DIV0 : DIV1;
                if (!rst_n) begin
                    cur_rise[k] = 0; cur_low[k] = 0; gap[k] = 0;
                    p_cs[k] = 1'b1; p_sclk[k] = 1'b0; p_mosi[k] = 1'b0; p_fd[k] = 1'b0;
                end else begin
                    if (!c) begin
                        if (p_cs[k]) begin
                            pend_gap[k] = gap[k];
                            cur_rise[k] = 0; cur_low[k] = 0; cur_word[k] = '0;
                            cur_tim[k]  = 1'b1; last_rise[k] = 0;
                        end
                        cur_low[k]++;
                        if (s && !p_sclk[k]) begin
                            cur_word[k] = {cur_word[k][14:0], m};
                            cur_rise[k]++;
                            if (cur_rise[k] == 1) begin
                                if (cur_low[k] != dv + 1) cur_tim[k] = 1'b0;
                            end else if (cur_low[k] - last_rise[k] != 2 * dv) begin
                                cur_tim[k] = 1'b0;
                            end
                            last_rise[k] = cur_low[k];
                        end
                    end else begin
                        if (!p_cs[k]) begin
                            if (mon_cnt[k] < MON_DEPTH) begin
                                mon_word[k][mon_cnt[k]] = cur_word[k];
                                mon_rise[k][mon_cnt[k]] = cur_rise[k];
                                mon_low [k][mon_cnt[k]] = cur_low[k];
                                mon_tim [k][mon_cnt[k]] = cur_tim[k];
                                mon_gap [k][mon_cnt[k]] = pend_gap[k];
                            end
                            mon_cnt[k]++;
                            gap[k] = 0;
                        end
                        if (gap[k] < 1000000) gap[k]++;
                        if (s || m) viol[k]++;
                    end
                    if (m != p_mosi[k] && c == p_cs[k] && !(p_sclk[k] && !s)) viol[k]++;
                    if (f) begin
                        fd_cnt[k]++;
                        if (p_fd[k] || !c || gap[k] != dv + 1) viol[k]++;
                    end
                    p_cs[k] = c; p_sclk[k] = s; p_mosi[k] = m; p_fd[k] = f;
                end
            end
        end
    end

    task automatic push(input int k, input logic [15:0] w);
        if (k == 0) exp0.push_back(w);
        else        exp1.push_back(w);
        exp_frames[k]++;
    endtask

    task automatic setsin(input int k, input logic [9:0] v);
        if (k == 0) sin0 = v;
        else        sin1 = v;
    endtask

    // Present one sample, hold it until the buffer takes it.
    task automatic offer(input int k, input logic [9:0] s, input logic [15:0] w);
        int t = 0;
        @(negedge clk);
        setsin(k, s);
        sval[k] = 1'b1;
        while (!rdy[k] && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) check($sformatf("d%0d_offer_timeout", k), 32'(t), 32'd0);
        else push(k, w);
        @(negedge clk);
        sval[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        while (!(busy[k] == 1'b0 && rdy[k] == 1'b1) && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) check($sformatf("d%0d_idle_timeout", k), 32'(t), 32'd0);
        repeat (4) @(posedge clk);
    endtask

    // Compare every newly captured frame with the scoreboard.
    task automatic drain(input int k);
        int dv;
        logic [15:0] w;
        dv = (k == 0) ? DIV0 : DIV1;
        wait_idle(k);
        while (chk_idx[k] < mon_cnt[k] && chk_idx[k] < MON_DEPTH) begin
            int i;
            i = chk_idx[k];
            $display("d%0d frame %0d: word=%04h rises=%0d cs_low=%0d", k, i,
                     mon_word[k][i], mon_rise[k][i], mon_low[k][i]);
            if ((k == 0 && exp0.size() == 0) || (k == 1 && exp1.size() == 0)) begin
                check($sformatf("d%0d_unexpected_frame", k), 32'(mon_word[k][i]), 32'hFFFF_FFFF);
            end else begin
                w = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                check($sformatf("d%0d_frame_word", k), 32'(mon_word[k][i]), 32'(w));
                check($sformatf("d%0d_sclk_rises", k), 32'(mon_rise[k][i]), 32'd16);
                check($sformatf("d%0d_cs_low_cycles", k), 32'(mon_low[k][i]), 32'(32 * dv));
                check($sformatf("d%0d_sclk_timing", k), 32'(mon_tim[k][i]), 32'd1);
            end
            chk_idx[k]++;
        end
        check($sformatf("d%0d_missing_frames", k),
              32'((k == 0) ? exp0.size() : exp1.size()), 32'd0);
        check($sformatf("d%0d_frame_count", k), 32'(mon_cnt[k]), 32'(exp_frames[k]));
        check($sformatf("d%0d_frame_done_count", k), 32'(fd_cnt[k]), 32'(exp_frames[k]));
        check($sformatf("d%0d_bus_protocol", k), 32'(viol[k]), 32'd0);
    endtask

    initial begin
        int         t, r, base;
        logic       ps;
        logic [9:0] s;

        // Reset state
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d_rst_cs_n", k),  32'(cs_n[k]), 32'd1);
            check($sformatf("d%0d_rst_sclk", k),  32'(sclk[k]), 32'd0);
            check($sformatf("d%0d_rst_mosi", k),  32'(mosi[k]), 32'd0);
            check($sformatf("d%0d_rst_busy", k),  32'(busy[k]), 32'd0);
            check($sformatf("d%0d_rst_fdone", k), 32'(fd[k]),   32'd0);
            check($sformatf("d%0d_rst_ready", k), 32'(rdy[k]),  32'd1);
        end
        #2 rst_n = 1'b1;

        // Single frame at CLK_DIV=2
        offer(0, 10'h2AA, lit(16'h3AA8, 16'h32A8));
        drain(0);

        // Back-to-back samples; second one lands in the buffer during SHIFT
        wait_idle(0);
        @(negedge clk);
        sin0 = 10'h3FF; sval[0] = 1'b1;
        check("bb_ready_before", 32'(rdy[0]), 32'd1);
        push(0, lit(16'h3FFC, 16'h37FC));
        @(negedge clk);
        sin0 = 10'h000;
        check("bb_ready_after_accept", 32'(rdy[0]), 32'd0);
        t = 0;
        while (!rdy[0] && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) check("bb_ready_timeout", 32'(t), 32'd0);
        check("bb_loaded_when_ready", 32'(cs_n[0]), 32'd0);
        push(0, lit(16'h3000, 16'h3800));
        @(negedge clk);
        sval[0] = 1'b0;
        check("bb_buffered_in_shift", 32'({rdy[0], cs_n[0]}), 32'd0);
        drain(0);

        // Reset at the 7th SCLK rise aborts the frame
        wait_idle(0);
        s = 10'($urandom);
        offer(0, s, model_frame(s));
        r = 0; t = 0; ps = sclk[0];
        while (r < 7 && t < TMO) begin
            @(negedge clk);
            t++;
            if (sclk[0] && !ps) r++;
            ps = sclk[0];
        end
        if (r < 7) check("abort_rise_timeout", 32'(r), 32'd7);
        check("abort_mid_frame", 32'(cs_n[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n",  32'(cs_n[0]), 32'd1);
        check("abort_sclk",  32'(sclk[0]), 32'd0);
        check("abort_mosi",  32'(mosi[0]), 32'd0);
        check("abort_busy",  32'(busy[0]), 32'd0);
        check("abort_fdone", 32'(fd[0]),   32'd0);
        check("abort_ready", 32'(rdy[0]),  32'd1);
        if (exp0.size() > 0) begin
            void'(exp0.pop_front());
            exp_frames[0]--;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        s = 10'($urandom);
        offer(0, s, model_frame(s));
        drain(0);

        // Sign-bit boundary samples
        offer(0, 10'h000, lit(16'h3000, 16'h3800));
        offer(0, 10'h1FF, lit(16'h37FC, 16'h3FFC));
        drain(0);

        // CLK_DIV=1 frame
        offer(1, 10'h155, lit(16'h3554, 16'h3D54));
        drain(1);

        // Continuous valid: four back-to-back frames per instance
        for (int k = 0; k < 2; k++) begin
            int acc;
            int dv;
            dv = (k == 0) ? DIV0 : DIV1;
            wait_idle(k);
            base = mon_cnt[k];
            acc = 0; t = 0;
            @(negedge clk);
            s = 10'($urandom);
            setsin(k, s);
            sval[k] = 1'b1;
            while (acc < 4 && t < TMO) begin
                if (rdy[k]) begin
                    push(k, model_frame(s));
                    acc++;
                    @(negedge clk);
                    s = 10'($urandom);
                    setsin(k, s);
                end else begin
                    @(negedge clk);
                end
                t++;
            end
            sval[k] = 1'b0;
            if (acc < 4) check($sformatf("d%0d_stream_timeout", k), 32'(acc), 32'd4);
            drain(k);
            check($sformatf("d%0d_stream_frames", k), 32'(mon_cnt[k] - base), 32'd4);
            for (int i = 1; i < 4; i++) begin
                if (base + i < MON_DEPTH)
                    check($sformatf("d%0d_stream_gap%0d", k, i), 32'(mon_gap[k][base + i]), 32'(dv + 1));
            end
        end

        // Randomised traffic on both instances
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                sval[k] = ($urandom_range(0, 3) == 0);
                s = 10'($urandom);
                setsin(k, s);
                if (sval[k] && rdy[k]) push(k, model_frame(s));
            end
        end
        @(negedge clk);
        sval = '0;
        drain(0);
        drain(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sine_dac_spi.md
SINE_DAC_SPI -- requirements
Module: sine_dac_spi

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per SCLK half-period, legal range 1..255.
REQ-002 SHALL have parameter CTRL_BITS, default 4'b0011: the 4-bit DAC command nibble sent at the start of each frame.
REQ-003 SHALL have port clk, input, 1: single clock; the sample domain is driven from clk_1Mhz.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port sample_in, input, 10: sample word from sine_wave_generator data_sin.
REQ-006 SHALL have port sample_valid, input, 1: sample_in is valid this cycle.
REQ-007 SHALL have port sample_ready, output, 1: block accepts a sample this cycle.
REQ-008 SHALL have port dac_cs_n, output, 1: DAC chip select, active low.
REQ-009 SHALL have port dac_sclk, output, 1: SPI clock, idle low (mode 0).
REQ-010 SHALL have port dac_mosi, output, 1: serial data, MSB first.
REQ-011 SHALL have port busy, output, 1: high while the FSM is not in IDLE.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse at the end of each frame.

Function
REQ-013 SHALL contain a one-entry holding buffer (buf_data, buf_valid); sample_ready = ~buf_valid (combinational).
REQ-014 SHALL load sample_in into the buffer and set buf_valid on any clk edge where sample_valid && sample_ready; samples with sample_ready low are not captured.
REQ-015 SHALL build each frame as the 16-bit word {CTRL_BITS, sample[9:0], 2'b00}, shifted MSB first.
REQ-016 SHALL use FSM states IDLE, SHIFT, HOLD; transitions IDLE->SHIFT when buf_valid, SHIFT->HOLD after the 16th SCLK falling edge, HOLD->IDLE after CLK_DIV cycles.
REQ-017 SHALL, on the IDLE->SHIFT edge, load the shift register from the buffer, clear buf_valid, drive dac_cs_n=0 and dac_mosi=bit15, and keep dac_sclk=0.
REQ-018 SHALL, in SHIFT, toggle dac_sclk every CLK_DIV clk cycles, with the first rise CLK_DIV cycles after cs_n falls, and update dac_mosi only on SCLK falling edges (stable at each rising edge).
REQ-019 SHALL produce exactly 16 SCLK rising edges per frame; dac_cs_n is low for exactly 32*CLK_DIV clk cycles (64 at the default).
REQ-020 SHALL drive dac_cs_n=1, dac_sclk=0 and dac_mosi=0 on entry to HOLD, and keep them through HOLD and IDLE.
REQ-021 SHALL pulse frame_done for one cycle on the HOLD->IDLE edge.
REQ-022 SHALL accept a new sample into the freed buffer during SHIFT or HOLD; that sample starts the next frame on the first IDLE cycle, giving back-to-back frames separated by HOLD plus one IDLE cycle.
REQ-023 SHALL give priority to the handshake when it and the buffer-to-shifter transfer fall in the same cycle, so no sample is lost or duplicated.
REQ-024 SHALL stop the SCLK divide counter at terminal count and wrap it to 0 at each toggle; the counter is 8 bits wide.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force state=IDLE, buf_valid=0, dac_cs_n=1, dac_sclk=0, dac_mosi=0, busy=0, frame_done=0, with the shift and divide counters at 0.
REQ-026 SHALL, when reset is asserted mid-frame, abort the frame and raise dac_cs_n immediately with no frame_done; sample_ready reads 1 during reset.

Configuration
REQ-027 SHALL, with macro SINE_DAC_TWOS_COMP_IN_EN defined, treat sample_in as two's complement and invert bit 9 before buffering (conversion to offset binary).
REQ-028 SHALL, without SINE_DAC_TWOS_COMP_IN_EN, pass sample_in to the frame unmodified as unsigned data.

Verification
REQ-029 SHALL cover: CLK_DIV=2, sample_in=10'h2AA accepted -> cs_n low 64 cycles, MOSI sampled on SCLK rise = 16'h3AA8, one frame_done.
REQ-030 SHALL cover: samples 10'h3FF then 10'h000 offered back-to-back -> second accepted during SHIFT, frames 16'h3FFC then 16'h3000, sample_ready low until the first frame loads.
REQ-031 SHALL cover: rst_n pulled low at the 7th SCLK rise -> cs_n=1, sclk=0, mosi=0 immediately, no frame_done, next sample produces a full correct frame.
REQ-032 SHALL cover: SINE_DAC_TWOS_COMP_IN_EN defined, sample_in=10'h000 -> frame 16'h3800; sample_in=10'h1FF -> frame 16'h37FC.
REQ-033 SHALL cover: CLK_DIV=1, sample 10'h155 -> cs_n low 32 cycles, frame 16'h3554, SCLK period 2 clk.
REQ-034 SHALL cover: sample_valid held high continuously for 4 frames -> exactly 4 frames, each separated by cs_n high for CLK_DIV+1 cycles.
